// File: rtl/cr_iu_wb_if.sv
// Writeback-stage bus: ALU/LSU results in, GPR write port, forwarding and stall out.
// The optional flush input is controlled by CR_IU_WB_FLUSH_EN and lives on cr_iu_wb itself.
interface cr_iu_wb_if #(
  parameter int DW = 32,
  parameter int IW = 5
);
  logic          alu_wb_vld;
  logic [IW-1:0] alu_wb_idx;
  logic [DW-1:0] alu_wb_data;
  logic          lsu_iu_ld_req;
  logic [IW-1:0] lsu_iu_ld_idx;
  logic          lsu_iu_wb_vld;
  logic          lsu_iu_wb_err;
  logic [DW-1:0] lsu_iu_wb_data;
  logic          wb_oper_write_en;
  logic [IW-1:0] wb_oper_write_idx;
  logic [DW-1:0] wb_oper_write_data;
  logic          wb_oper_fwd_en;
  logic [DW-1:0] wb_oper_fwd_data_no_load;
  logic [IW-1:0] wb_oper_write_idx_for_dep;
  logic          wb_ctrl_stall;

  modport master (
    output alu_wb_vld, alu_wb_idx, alu_wb_data,
    output lsu_iu_ld_req, lsu_iu_ld_idx, lsu_iu_wb_vld, lsu_iu_wb_err, lsu_iu_wb_data,
    input  wb_oper_write_en, wb_oper_write_idx, wb_oper_write_data,
    input  wb_oper_fwd_en, wb_oper_fwd_data_no_load, wb_oper_write_idx_for_dep, wb_ctrl_stall
  );

  modport slave (
    input  alu_wb_vld, alu_wb_idx, alu_wb_data,
    input  lsu_iu_ld_req, lsu_iu_ld_idx, lsu_iu_wb_vld, lsu_iu_wb_err, lsu_iu_wb_data,
    output wb_oper_write_en, wb_oper_write_idx, wb_oper_write_data,
    output wb_oper_fwd_en, wb_oper_fwd_data_no_load, wb_oper_write_idx_for_dep, wb_ctrl_stall
  );
endinterface

// File: rtl/cr_iu_wb.sv
// Integer-unit writeback: merges ALU and load returns onto one GPR write port.
// Optional flush input enabled by defining CR_IU_WB_FLUSH_EN.
module cr_iu_wb #(
  parameter int DW = 32,
  parameter int IW = 5
) (
  input logic forever_cpuclk,
  input logic iu_yy_xx_reg_rst,
`ifdef CR_IU_WB_FLUSH_EN
  input logic iu_wb_flush,
`endif
  cr_iu_wb_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, LD_WAIT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          buf_vld_q, buf_vld_d;
  logic [IW-1:0] buf_idx_q, buf_idx_d;
  logic [DW-1:0] buf_data_q, buf_data_d;
  logic [IW-1:0] ld_idx_q, ld_idx_d;

  logic          flush;
  logic          ld_ret, alu_acc, ld_acc;
  logic          wr_vld;
  logic [IW-1:0] wr_idx;
  logic [DW-1:0] wr_data;

`ifdef CR_IU_WB_FLUSH_EN
  assign flush = iu_wb_flush;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    buf_vld_d  = 1'b0;
    buf_idx_d  = buf_idx_q;
    buf_data_d = buf_data_q;
    ld_idx_d   = ld_idx_q;
    wr_vld     = 1'b0;
    wr_idx     = '0;
    wr_data    = '0;

    // Returns outside LD_WAIT are stale and ignored; ALU is only refused while the buffer drains.
    ld_ret  = (state_q == LD_WAIT) & bus.lsu_iu_wb_vld;
    alu_acc = bus.alu_wb_vld & ~buf_vld_q;
    ld_acc  = bus.lsu_iu_ld_req & ~buf_vld_q & ((state_q == IDLE) | ld_ret);

    if (buf_vld_q) begin
      wr_vld  = 1'b1;
      wr_idx  = buf_idx_q;
      wr_data = buf_data_q;
    end else if (ld_ret & ~bus.lsu_iu_wb_err) begin
      wr_vld  = 1'b1;
      wr_idx  = ld_idx_q;
      wr_data = bus.lsu_iu_wb_data;
      if (alu_acc) begin
        buf_vld_d  = 1'b1;
        buf_idx_d  = bus.alu_wb_idx;
        buf_data_d = bus.alu_wb_data;
      end
    end else if (alu_acc) begin
      wr_vld  = 1'b1;
      wr_idx  = bus.alu_wb_idx;
      wr_data = bus.alu_wb_data;
    end

    if (ld_ret) state_d = IDLE;
    if (ld_acc) begin
      state_d  = LD_WAIT;
      ld_idx_d = bus.lsu_iu_ld_idx;
    end

    if (flush) begin
      state_d   = IDLE;
      buf_vld_d = 1'b0;
      wr_vld    = 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge iu_yy_xx_reg_rst) begin
    if (iu_yy_xx_reg_rst) begin
      state_q    <= IDLE;
      buf_vld_q  <= 1'b0;
      buf_idx_q  <= '0;
      buf_data_q <= '0;
      ld_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      buf_vld_q  <= buf_vld_d;
      buf_idx_q  <= buf_idx_d;
      buf_data_q <= buf_data_d;
      ld_idx_q   <= ld_idx_d;
    end
  end

  // Combinational outputs are forced low while reset is held so nothing leaks mid-reset.
  assign bus.wb_oper_write_en          = ~iu_yy_xx_reg_rst & wr_vld & (|wr_idx);
  assign bus.wb_oper_write_idx         = iu_yy_xx_reg_rst ? '0 : wr_idx;
  assign bus.wb_oper_write_data        = iu_yy_xx_reg_rst ? '0 : wr_data;
  assign bus.wb_oper_fwd_en            = ~iu_yy_xx_reg_rst & (state_q == IDLE) & alu_acc & ~flush;
  assign bus.wb_oper_fwd_data_no_load  = iu_yy_xx_reg_rst ? '0 : bus.alu_wb_data;
  assign bus.wb_oper_write_idx_for_dep = iu_yy_xx_reg_rst ? '0 :
                                         ((state_q == LD_WAIT) ? ld_idx_q : bus.alu_wb_idx);
  assign bus.wb_ctrl_stall             = ~iu_yy_xx_reg_rst & (buf_vld_q | (state_q == LD_WAIT));

endmodule

// File: tb/tb_cr_iu_wb.sv
// Self-checking bench for cr_iu_wb: per-cycle vector table fed through an expectation queue,
// plus a hand-written reset-during-buffer-drain sequence.
module tb_cr_iu_wb;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int NVEC = 27;

  logic clk = 1'b0;
  logic rst;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cr_iu_wb_if #(.DW(DW), .IW(IW)) bus ();

  cr_iu_wb #(.DW(DW), .IW(IW)) dut (
    .forever_cpuclk   (clk),
    .iu_yy_xx_reg_rst (rst),
`ifdef CR_IU_WB_FLUSH_EN
    .iu_wb_flush      (flush),
`endif
    .bus              (bus)
  );

  typedef struct {
    int aluVld; int aluIdx; int aluData;
    int ldReq;  int ldIdx;
    int wbVld;  int wbErr;  int wbData;
    int eWe;    int eIdx;   int eData;
    int eFwd;   int eFdata; int eDep;  int eStall;
  } vec_t;

  vec_t vecs [NVEC];
  vec_t expQ [$];
  string tagQ [$];
  int   total  = 0;
  int   passed = 0;
  logic prevCollision = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic driveIdle();
    bus.alu_wb_vld     = 1'b0;
    bus.alu_wb_idx     = '0;
    bus.alu_wb_data    = '0;
    bus.lsu_iu_ld_req  = 1'b0;
    bus.lsu_iu_ld_idx  = '0;
    bus.lsu_iu_wb_vld  = 1'b0;
    bus.lsu_iu_wb_err  = 1'b0;
    bus.lsu_iu_wb_data = '0;
  endtask

  // Drive one cycle of stimulus just after the edge and queue what the DUT must show.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    assert (!(v.aluVld != 0 && prevCollision))
      else $error("[TB] illegal alu_wb_vld presented during buffer drain (%s)", tag);
    bus.alu_wb_vld     = v.aluVld[0];
    bus.alu_wb_idx     = v.aluIdx[IW-1:0];
    bus.alu_wb_data    = v.aluData;
    bus.lsu_iu_ld_req  = v.ldReq[0];
    bus.lsu_iu_ld_idx  = v.ldIdx[IW-1:0];
    bus.lsu_iu_wb_vld  = v.wbVld[0];
    bus.lsu_iu_wb_err  = v.wbErr[0];
    bus.lsu_iu_wb_data = v.wbData;
    prevCollision      = (v.wbVld != 0) && (v.aluVld != 0) && (v.wbErr == 0);
    expQ.push_back(v);
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput();
    vec_t  e;
    string t;
    @(negedge clk);
    if (expQ.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      check({t, ".write_en"}, 32'(bus.wb_oper_write_en), e.eWe);
      if (e.eWe != 0) begin
        check({t, ".write_idx"},  32'(bus.wb_oper_write_idx), e.eIdx);
        check({t, ".write_data"}, 32'(bus.wb_oper_write_data), e.eData);
      end
      check({t, ".fwd_en"}, 32'(bus.wb_oper_fwd_en), e.eFwd);
      if (e.eFwd != 0)
        check({t, ".fwd_data"}, 32'(bus.wb_oper_fwd_data_no_load), e.eFdata);
      check({t, ".idx_for_dep"}, 32'(bus.wb_oper_write_idx_for_dep), e.eDep);
      check({t, ".stall"}, 32'(bus.wb_ctrl_stall), e.eStall);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".write_en"},    32'(bus.wb_oper_write_en), 0);
    check({tag, ".write_idx"},   32'(bus.wb_oper_write_idx), 0);
    check({tag, ".write_data"},  32'(bus.wb_oper_write_data), 0);
    check({tag, ".fwd_en"},      32'(bus.wb_oper_fwd_en), 0);
    check({tag, ".fwd_data"},    32'(bus.wb_oper_fwd_data_no_load), 0);
    check({tag, ".idx_for_dep"}, 32'(bus.wb_oper_write_idx_for_dep), 0);
    check({tag, ".stall"},       32'(bus.wb_ctrl_stall), 0);
  endtask

  initial begin
    //             aluV idx data    ldR ldI wbV err wbData  we  idx data    fwd fdata   dep stall
    vecs[0]  = '{1,  5,  'h1234, 0,  0,  0,  0,  0,      1,  5,  'h1234, 1,  'h1234, 5,  0};
    vecs[1]  = '{0,  0,  0,      0,  0,  0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[2]  = '{0,  0,  0,      1,  7,  0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[3]  = '{0,  0,  0,      0,  0,  0,  0,  0,      0,  0,  0,      0,  0,      7,  1};
    vecs[4]  = '{0,  0,  0,      0,  0,  0,  0,  0,      0,  0,  0,      0,  0,      7,  1};
    vecs[5]  = '{0,  0,  0,      0,  0,  1,  0,  'hDEAD, 1,  7,  'hDEAD, 0,  0,      7,  1};
    vecs[6]  = '{0,  0,  0,      0,  0,  0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[7]  = '{0,  0,  0,      1,  3,  0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[8]  = '{1,  9,  'h55,   0,  0,  0,  0,  0,      1,  9,  'h55,   0,  0,      3,  1};
    vecs[9]  = '{1,  4,  'hB,    0,  0,  1,  0,  'hA,    1,  3,  'hA,    0,  0,      3,  1};
    vecs[10] = '{0,  0,  0,      0,  0,  0,  0,  0,      1,  4,  'hB,    0,  0,      0,  1};
    vecs[11] = '{0,  0,  0,      0,  0,  0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[12] = '{0,  0,  0,      1,  6,  0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[13] = '{1,  8,  'h88,   0,  0,  1,  1,  'h77,   1,  8,  'h88,   0,  0,      6,  1};
    vecs[14] = '{1,  0,  'h99,   0,  0,  0,  0,  0,      0,  0,  0,      1,  'h99,   0,  0};
    vecs[15] = '{0,  0,  0,      1,  2,  0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[16] = '{0,  0,  0,      0,  0,  1,  1,  'h5A5,  0,  0,  0,      0,  0,      2,  1};
    vecs[17] = '{0,  0,  0,      0,  0,  0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[18] = '{0,  0,  0,      1,  12, 0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[19] = '{1,  12, 'h222,  0,  0,  1,  0,  'h111,  1,  12, 'h111,  0,  0,      12, 1};
    vecs[20] = '{0,  0,  0,      0,  0,  0,  0,  0,      1,  12, 'h222,  0,  0,      0,  1};
    vecs[21] = '{0,  0,  0,      0,  0,  0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[22] = '{0,  0,  0,      1,  10, 0,  0,  0,      0,  0,  0,      0,  0,      0,  0};
    vecs[23] = '{0,  0,  0,      1,  11, 1,  0,  'h333,  1,  10, 'h333,  0,  0,      10, 1};
    vecs[24] = '{0,  0,  0,      0,  0,  0,  0,  0,      0,  0,  0,      0,  0,      11, 1};
    vecs[25] = '{0,  0,  0,      0,  0,  1,  0,  'h444,  1,  11, 'h444,  0,  0,      11, 1};
    vecs[26] = '{0,  0,  0,      0,  0,  0,  0,  0,      0,  0,  0,      0,  0,      0,  0};

    rst = 1'b1;
    driveIdle();
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
      checkOutput();
    end

    // Reset asserted while the collision buffer holds r4=0xB.
    applyStimulus('{0, 0, 0, 1, 3, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0}, "rst_ld");
    checkOutput();
    applyStimulus('{1, 4, 'hB, 0, 0, 1, 0, 'hA,   1, 3, 'hA,   0, 0, 3, 1}, "rst_coll");
    checkOutput();
    @(posedge clk);
    #1;
    driveIdle();
    rst = 1'b1;
    #2;
    checkAllZero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus('{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0}, "rst_after");
    checkOutput();
    applyStimulus('{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0}, "rst_after2");
    checkOutput();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
